// File: rtl/booth_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// booth_mul_seq_pkg
//   Shared definitions for the sequential radix-4 Booth multiplier and its
//   digit recoder. The recoder is also intended for a future pipelined
//   multiplier, so the select encoding lives here rather than in either user.
//
//   Contents:
//     state_t      - controller state encoding (IDLE / RUN / DONE)
//     booth_sel_t  - symbolic Booth digit selection (ZERO, POS1, POS2, NEG1, NEG2)
//     booth_ctl_t  - decoded select bundle {neg, two, zero} driving the adder
//     sel_to_ctl() - maps a symbolic selection onto the control bundle
//     booth_iter() - number of Booth digits retired for a given operand width
// -----------------------------------------------------------------------------
package booth_mul_seq_pkg;

    // Controller states. The encoding is visible on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Symbolic selection for one radix-4 Booth digit.
    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_POS1 = 3'd1,
        SEL_POS2 = 3'd2,
        SEL_NEG1 = 3'd3,
        SEL_NEG2 = 3'd4
    } booth_sel_t;

    // Control bundle consumed by the adder:
    //   zero - addend is 0 (neg is forced low so no stray carry-in)
    //   two  - addend is 2*Mx instead of Mx
    //   neg  - addend is subtracted (invert plus carry-in)
    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_ctl_t;

    function automatic booth_ctl_t sel_to_ctl(input booth_sel_t sel);
        booth_ctl_t ctl;
        ctl = '{neg: 1'b0, two: 1'b0, zero: 1'b1};
        case (sel)
            SEL_POS1: ctl = '{neg: 1'b0, two: 1'b0, zero: 1'b0};
            SEL_POS2: ctl = '{neg: 1'b0, two: 1'b1, zero: 1'b0};
            SEL_NEG1: ctl = '{neg: 1'b1, two: 1'b0, zero: 1'b0};
            SEL_NEG2: ctl = '{neg: 1'b1, two: 1'b1, zero: 1'b0};
            default:  ctl = '{neg: 1'b0, two: 1'b0, zero: 1'b1};
        endcase
        return ctl;
    endfunction

    // One extra digit beyond WIDTH/2 so that zero-extended (unsigned)
    // operands whose MSB is set are still multiplied correctly.
    function automatic int booth_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_mul_seq_recode.sv
// -----------------------------------------------------------------------------
// booth_r4_recode
//   Purely combinational radix-4 Booth recoder. Takes the 3-bit overlapping
//   window {q[1], q[0], q_m1} and produces the adder control bundle.
//
//   Ports:
//     i_digit  in   3   Booth window {q[1], q[0], q_m1}
//     o_ctl    out  3   {neg, two, zero} select for the partial-product adder
// -----------------------------------------------------------------------------
module booth_r4_recode
    import booth_mul_seq_pkg::*;
(
    input  logic [2:0] i_digit,
    output booth_ctl_t o_ctl
);

    booth_sel_t w_sel;

    always_comb begin
        w_sel = SEL_ZERO;
        case (i_digit)
            3'b000:  w_sel = SEL_ZERO;
            3'b001:  w_sel = SEL_POS1;
            3'b010:  w_sel = SEL_POS1;
            3'b011:  w_sel = SEL_POS2;
            3'b100:  w_sel = SEL_NEG2;
            3'b101:  w_sel = SEL_NEG1;
            3'b110:  w_sel = SEL_NEG1;
            3'b111:  w_sel = SEL_ZERO;
            default: w_sel = SEL_ZERO;
        endcase
    end

    assign o_ctl = sel_to_ctl(w_sel);

endmodule

// File: rtl/booth_mul_seq.sv
// -----------------------------------------------------------------------------
// booth_mul_seq
//   Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
//   unsigned per operation. One Booth digit (two multiplier bits) is retired
//   per clock through a single WIDTH+2-bit adder.
//
//   Handshake: start is only looked at in IDLE. The cycle in which start is
//   high at a rising edge while IDLE is the accept; operands and is_signed are
//   captured then and ignored afterwards. done is a single-cycle pulse in which
//   product/hi/lo are valid; they then hold until the next accept or clr.
//   start during RUN or DONE is dropped, not queued.
//
//   Ports:
//     clk           in   1         rising-edge clock
//     clr           in   1         synchronous active-high reset
//     start         in   1         operation request (IDLE only)
//     is_signed     in   1         1 = two's-complement operands
//     multiplicand  in   WIDTH     operand M
//     multiplier    in   WIDTH     operand Q
//     busy          out  1         high while in RUN
//     done          out  1         one-cycle completion pulse
//     product       out  2*WIDTH   result
//     hi            out  WIDTH     upper half of product
//     lo            out  WIDTH     lower half of product
//     dbg_state     out  2         current controller state
// -----------------------------------------------------------------------------
module booth_mul_seq
    import booth_mul_seq_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo,
    output logic [1:0]           dbg_state
);

    localparam int XW    = WIDTH + 2;
    localparam int ITER  = booth_iter(WIDTH);
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [XW-1:0]        r_mx;
    logic [XW-1:0]        r_acc;
    logic [XW-1:0]        r_q;
    logic                 r_q_m1;
    logic [CNT_W-1:0]     r_iter;
    logic [2*WIDTH-1:0]   r_product;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_last;
    booth_ctl_t           w_ctl;
    logic [XW-1:0]        w_addend;
    logic [XW-1:0]        w_opnd;
    logic [XW-1:0]        w_sum;
    logic [XW-1:0]        w_acc_nxt;
    logic [XW-1:0]        w_q_nxt;
    logic                 w_q_m1_nxt;
    logic [XW-1:0]        w_mx_ext;
    logic [XW-1:0]        w_qx_ext;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_state == ST_RUN) && (r_iter == LAST_ITER);

    // Operand extension to WIDTH+2 bits. The two guard bits let 2*Mx be
    // formed by a plain left shift and keep the running sum's sign in the MSB.
    assign w_mx_ext = {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
    assign w_qx_ext = {{2{is_signed & multiplier[WIDTH-1]}},   multiplier};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: recode, add, shift
    // ------------------------------------------------------------------
    booth_r4_recode u_recode (
        .i_digit ({r_q[1], r_q[0], r_q_m1}),
        .o_ctl   (w_ctl)
    );

    always_comb begin
        w_addend = '0;
        if (!w_ctl.zero) begin
            w_addend = w_ctl.two ? {r_mx[XW-2:0], 1'b0} : r_mx;
        end
    end

    // Subtraction as invert plus carry-in keeps a single adder.
    assign w_opnd = w_addend ^ {XW{w_ctl.neg}};
    assign w_sum  = r_acc + w_opnd + {{(XW-1){1'b0}}, w_ctl.neg};

    // Arithmetic shift right by 2 of {sum, q, q_m1}.
    assign w_acc_nxt  = {{2{w_sum[XW-1]}}, w_sum[XW-1:2]};
    assign w_q_nxt    = {w_sum[1:0], r_q[XW-1:2]};
    assign w_q_m1_nxt = r_q[1];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_mx   <= '0;
            r_acc  <= '0;
            r_q    <= '0;
            r_q_m1 <= 1'b0;
            r_iter <= '0;
        end else if (w_accept) begin
            r_mx   <= w_mx_ext;
            r_acc  <= '0;
            r_q    <= w_qx_ext;
            r_q_m1 <= 1'b0;
            r_iter <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc  <= w_acc_nxt;
            r_q    <= w_q_nxt;
            r_q_m1 <= w_q_m1_nxt;
            r_iter <= r_iter + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result register. Loaded from the final shifted values on the edge
    // that leaves RUN, so it is valid during the done cycle and never
    // changes mid-operation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_product <= '0;
        end else if (w_last) begin
            r_product <= {w_acc_nxt[WIDTH-3:0], w_q_nxt};
        end
    end

    assign product   = r_product;
    assign hi        = r_product[2*WIDTH-1:WIDTH];
    assign lo        = r_product[WIDTH-1:0];
    assign dbg_state = r_state;

endmodule

// File: tb/tb_booth_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mul_seq
//   Directed bench for booth_mul_seq. A 32-bit instance covers latency,
//   sign/boundary vectors and the protocol/reset behaviour; an 8-bit instance
//   is swept over a grid of operand pairs in both modes against '*'.
// -----------------------------------------------------------------------------
module tb_booth_mul_seq;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    // 32-bit DUT
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        busy, done;
    logic [63:0] product;
    logic [31:0] hi, lo;
    logic [1:0]  dbg_state;

    // 8-bit DUT
    logic        s8_start = 1'b0;
    logic        s8_signed = 1'b0;
    logic [7:0]  s8_m = '0;
    logic [7:0]  s8_q = '0;
    logic        s8_busy, s8_done;
    logic [15:0] s8_product;
    logic [7:0]  s8_hi, s8_lo;
    logic [1:0]  s8_state;

    int n_tests = 0;
    int n_fail  = 0;

    booth_mul_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .clr(clr), .start(start), .is_signed(is_signed),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product), .hi(hi), .lo(lo),
        .dbg_state(dbg_state)
    );

    booth_mul_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .clr(clr), .start(s8_start), .is_signed(s8_signed),
        .multiplicand(s8_m), .multiplier(s8_q),
        .busy(s8_busy), .done(s8_done), .product(s8_product), .hi(s8_hi), .lo(s8_lo),
        .dbg_state(s8_state)
    );

    // ------------------------------------------------------------------
    // Check helper
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks. Inputs change on the falling edge; outputs are sampled
    // on the falling edge. lat counts rising edges from the accept edge
    // (inclusive) up to the edge after which done is seen high.
    // Operands are scrambled right after accept to show they are not reused.
    // ------------------------------------------------------------------
    task automatic op32(input logic sg, input logic [31:0] m, input logic [31:0] q,
                        output logic [63:0] p, output int lat);
        @(negedge clk);
        start = 1'b1; is_signed = sg; multiplicand = m; multiplier = q;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
        is_signed = $urandom_range(0, 1);
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        p = product;
    endtask

    task automatic op8(input logic sg, input logic [7:0] m, input logic [7:0] q,
                       output logic [15:0] p, output int lat);
        @(negedge clk);
        s8_start = 1'b1; s8_signed = sg; s8_m = m; s8_q = q;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        s8_start = 1'b0; s8_m = $urandom; s8_q = $urandom;
        while (!s8_done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        p = s8_product;
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [63:0] p;
        logic [15:0] p8;
        logic [15:0] e8;
        int          lat;
        int          dones;
        int          doubles;
        logic        prev;
        logic [7:0]  vals[20];
        logic signed [7:0] sa, sb;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",    {63'd0, busy},      64'd0);
        chk("reset_done",    {63'd0, done},      64'd0);
        chk("reset_product", product,            64'd0);
        chk("reset_state",   {62'd0, dbg_state}, 64'd0);
        clr = 1'b0;

        // 1. 2 * 5 signed, latency and halves
        op32(1'b1, 32'd2, 32'd5, p, lat);
        chk("t1_latency", 64'(lat), 64'd18);
        chk("t1_product", p, 64'd10);
        chk("t1_hi", {32'd0, hi}, 64'd0);
        chk("t1_lo", {32'd0, lo}, 64'd10);
        @(negedge clk);
        chk("t1_done_one_cycle", {63'd0, done}, 64'd0);
        chk("t1_product_held", product, 64'd10);

        // 2. signed negative operands in both positions
        op32(1'b1, 32'hFFFF_FFFE, 32'd5, p, lat);
        chk("t2_neg2x5", p, 64'hFFFF_FFFF_FFFF_FFF6);
        op32(1'b1, 32'd5, 32'hFFFF_FFFE, p, lat);
        chk("t2_5xneg2", p, 64'hFFFF_FFFF_FFFF_FFF6);
        chk("t2_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);

        // 3. all-ones operands, unsigned then signed
        op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat);
        chk("t3_unsigned_ones", p, 64'hFFFF_FFFE_0000_0001);
        op32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat);
        chk("t3_signed_ones", p, 64'd1);

        // 4. most-negative boundary
        op32(1'b1, 32'h8000_0000, 32'h8000_0000, p, lat);
        chk("t4_min_x_min", p, 64'h4000_0000_0000_0000);
        op32(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, p, lat);
        chk("t4_min_x_max", p, 64'hC000_0000_8000_0000);
        op32(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, p, lat);
        chk("t4_max_x_max", p, 64'h3FFF_FFFF_0000_0001);
        op32(1'b0, 32'hFFFF_FFFF, 32'd2, p, lat);
        chk("t4_unsigned_ones_x2", p, 64'h0000_0001_FFFF_FFFE);
        op32(1'b0, 32'h8000_0000, 32'h8000_0000, p, lat);
        chk("t4_unsigned_msb_sq", p, 64'h4000_0000_0000_0000);

        // 5a. start held high for 40 cycles: two results inside the window,
        //     each with a single-cycle done.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; multiplicand = 32'd3; multiplier = 32'd7;
        dones = 0; doubles = 0; prev = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dones++;
                if (prev) doubles++;
            end
            prev = done;
        end
        start = 1'b0;
        chk("t5_hold_done_count", 64'(dones), 64'd2);
        chk("t5_hold_done_width", 64'(doubles), 64'd0);
        chk("t5_hold_product", product, 64'd21);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // 5b. operand change and extra start mid-RUN are ignored
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; multiplicand = 32'd1000; multiplier = 32'd1000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; is_signed = 1'b1; multiplicand = 32'hFFFF_FFFF; multiplier = 32'd9;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t5_midrun_done_seen", {63'd0, done}, 64'd1);
        chk("t5_midrun_product", product, 64'd1_000_000);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("t5_midrun_start_dropped", 64'(dones), 64'd0);

        // 5c. clr on cycle 5 of RUN
        op32(1'b0, 32'd6, 32'd7, p, lat);
        chk("t5_pre_clr_product", p, 64'd42);
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; multiplicand = 32'd9; multiplier = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_busy_before_clr", {63'd0, busy}, 64'd1);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        chk("t5_clr_busy", {63'd0, busy}, 64'd0);
        chk("t5_clr_done", {63'd0, done}, 64'd0);
        chk("t5_clr_product", product, 64'd0);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("t5_clr_no_done", 64'(dones), 64'd0);

        // 6. WIDTH=8 grid sweep, both modes
        for (int i = 0; i < 18; i++) vals[i] = 8'(i * 15);
        vals[18] = 8'h7F;
        vals[19] = 8'h80;
        op8(1'b1, 8'd3, 8'd5, p8, lat);
        chk("w8_latency", 64'(lat), 64'd6);
        chk("w8_first", {48'd0, p8}, 64'd15);
        for (int md = 0; md < 2; md++) begin
            for (int i = 0; i < 20; i++) begin
                for (int j = 0; j < 20; j++) begin
                    op8(md[0], vals[i], vals[j], p8, lat);
                    if (md == 1) begin
                        sa = vals[i];
                        sb = vals[j];
                        e8 = 16'(sa * sb);
                    end else begin
                        e8 = {8'd0, vals[i]} * {8'd0, vals[j]};
                    end
                    chk($sformatf("w8_%s_%02h_%02h", md ? "s" : "u", vals[i], vals[j]),
                        {48'd0, p8}, {48'd0, e8});
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
